// File: rtl/decrypt_unit.sv
// decrypt_unit: undoes the byte encrypter (rotating 3-byte key XOR plus inverse bit permutation)
// and buffers plaintext in a small FWFT FIFO with ready/valid on both sides.
module decrypt_unit #(
    parameter logic [7:0]  KEY1  = 8'hA5,
    parameter logic [7:0]  KEY2  = 8'h3C,
    parameter logic [7:0]  KEY3  = 8'h96,
    parameter logic [23:0] PERM  = 24'h053977,
    parameter int          DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       en,
    input  logic       resync,
    output logic       in_rdy,
    output logic [7:0] dout,
    output logic       v,
    input  logic       out_rdy,
    output logic       ovf
);
    localparam int AW = $clog2(DEPTH);

    function automatic bit perm_ok(input logic [23:0] p);
        logic [7:0] seen;
        seen = '0;
        for (int i = 0; i < 8; i++) seen[p[3*i +: 3]] = 1'b1;
        return &seen;
    endfunction

    generate
        if (!perm_ok(PERM)) begin : g_perm_chk
            $error("decrypt_unit: PERM is not a bijection of 0..7");
        end
    endgenerate

    logic [1:0]    ptr;
    logic          s1_v;
    logic [7:0]    din_ff, key_ff, cur_key, x, plain;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic          accept, pop;

    assign cur_key = (resync || ptr == 2'd0) ? KEY3 : (ptr == 2'd1) ? KEY1 : KEY2;
    // counting the stage-1 byte guarantees it always has a FIFO slot on the following edge
    assign in_rdy  = (count + (AW+1)'(s1_v)) <= (AW+1)'(DEPTH - 1);
    assign accept  = en & in_rdy;
    assign v       = count != '0;
    assign pop     = v & out_rdy;
    assign dout    = mem[rp];
    assign x       = din_ff ^ key_ff;

    always_comb begin
        plain = '0;
        for (int i = 0; i < 8; i++) plain[PERM[3*i +: 3]] = x[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= 2'd0;
            s1_v   <= 1'b0;
            din_ff <= '0;
            key_ff <= '0;
            wp     <= '0;
            rp     <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            s1_v <= accept;
            if (accept) begin
                din_ff <= din;
                key_ff <= cur_key;
                ptr    <= resync ? 2'd1 : (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
            end else if (resync) begin
                ptr <= 2'd0;
            end
            if (en && !in_rdy) ovf <= 1'b1;
            if (s1_v) begin
                mem[wp] <= plain;
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(s1_v) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_decrypt_unit.sv
// tb_decrypt_unit: vector table plus scoreboard bench; expected plaintext is queued when a byte
// is accepted and checked whenever the DUT hands a byte to the consumer.
module tb_decrypt_unit;
    localparam logic [7:0]  K1 = 8'hA5, K2 = 8'h3C, K3 = 8'h96;
    localparam logic [23:0] PERM_T = 24'h053977;
    localparam int          DEPTH = 4;

    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] din = '0;
    logic       en = 1'b0, resync = 1'b0, out_rdy = 1'b1;
    logic       in_rdy, v, ovf;
    logic [7:0] dout;

    decrypt_unit #(.KEY1(K1), .KEY2(K2), .KEY3(K3), .PERM(PERM_T), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .din(din), .en(en), .resync(resync), .in_rdy(in_rdy),
        .dout(dout), .v(v), .out_rdy(out_rdy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         en;
        logic [7:0] din;
        bit         rs;
        logic [7:0] exp;
    } vec_t;

    logic [7:0] sb[$];
    int n_cmp = 0, n_bad = 0, kp = 0, acc_cnt = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] key_of(input int ph);
        return ph == 0 ? K3 : ph == 1 ? K1 : K2;
    endfunction

    // reference encrypter: scrambled[i] = plain[p_i], then XOR with the key byte
    function automatic logic [7:0] encrypt(input logic [7:0] p, input int ph);
        logic [23:0] pm;
        logic [7:0]  s;
        pm = PERM_T;
        for (int i = 0; i < 8; i++) s[i] = p[pm[3*i +: 3]];
        return s ^ key_of(ph);
    endfunction

    always @(negedge clk) begin
        if (!rst && v && out_rdy) begin
            if (sb.size() == 0) check("unexpected_output", {24'h0, dout}, 32'hFFFF_FFFF);
            else check("dout", {24'h0, dout}, {24'h0, sb.pop_front()});
        end
    end

    task automatic send(input bit e, input logic [7:0] d, input bit rs, input logic [7:0] exp);
        en = e; din = d; resync = rs;
        if (e && in_rdy) begin
            sb.push_back(exp);
            acc_cnt++;
            kp = rs ? 1 : (kp + 1) % 3;
        end else if (rs) begin
            kp = 0;
        end
        @(posedge clk); #1;
        en = 1'b0; resync = 1'b0;
    endtask

    task automatic send_plain(input logic [7:0] p);
        send(1'b1, encrypt(p, kp), 1'b0, p);
    endtask

    task automatic do_reset();
        rst = 1'b1; sb.delete(); kp = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check(name, sb.size(), 0);
    endtask

    vec_t vt[$];
    logic [7:0] held;

    initial begin
        vt = '{
            '{1, 8'h3C, 0, 8'h55}, '{1, 8'hA5, 0, 8'h00}, '{1, 8'h3C, 0, 8'h00},
            '{1, 8'h96, 0, 8'h00}, '{1, 8'hA5, 0, 8'h00}, '{1, 8'h96, 1, 8'h00},
            '{1, 8'hA5, 0, 8'h00}, '{1, 8'h3C, 0, 8'h00}, '{1, 8'hFF, 0, 8'h96},
            '{0, 8'h00, 1, 8'h00}, '{1, 8'h96, 0, 8'h00}
        };
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("rst_v", v, 0);
        check("rst_dout", dout, 0);
        check("rst_in_rdy", in_rdy, 1);
        check("rst_ovf", ovf, 0);

        send(1'b1, 8'h96, 1'b0, 8'h00);
        check("lat_v_edge1", v, 0);
        @(posedge clk); #1;
        check("lat_v_edge2", v, 1);
        check("lat_dout_edge2", dout, 8'h00);
        check("lat_ovf", ovf, 0);
        wait_drain("drain_first");

        do_reset();
        foreach (vt[i]) send(vt[i].en, vt[i].din, vt[i].rs, vt[i].exp);
        wait_drain("drain_table");

        for (int i = 0; i < 64; i++) begin
            while ($urandom_range(0, 2) == 0) send(1'b0, 8'h00, 1'b0, 8'h00);
            send_plain(8'($urandom));
        end
        wait_drain("drain_random");

        out_rdy = 1'b0; acc_cnt = 0;
        for (int i = 0; i < 6; i++) send_plain(8'(8'h10 + i));
        check("bp_accepted", acc_cnt, DEPTH);
        check("bp_in_rdy", in_rdy, 0);
        check("bp_ovf", ovf, 1);
        check("bp_v", v, 1);
        held = dout;
        @(posedge clk); #1;
        check("bp_hold", dout, held);
        check("bp_head", dout, sb[0]);
        out_rdy = 1'b1;
        wait_drain("drain_bp");
        send_plain(8'h5A);
        send_plain(8'hC3);
        wait_drain("drain_after_bp");
        check("ovf_sticky", ovf, 1);

        out_rdy = 1'b0;
        send_plain(8'h01); send_plain(8'h02); send_plain(8'h03);
        send_plain(8'h04);
        #2 rst = 1'b1;
        #1;
        check("arst_v", v, 0);
        check("arst_ovf", ovf, 0);
        check("arst_in_rdy", in_rdy, 1);
        sb.delete(); kp = 0;
        @(posedge clk); #1;
        rst = 1'b0; out_rdy = 1'b1;
        send(1'b1, 8'h96, 1'b0, 8'h00);
        send_plain(8'h77);
        wait_drain("drain_after_arst");
        repeat (3) @(posedge clk);
        #1;
        check("final_v", v, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
